// File: rtl/fb_arbiter_if.sv
// Frame-buffer arbiter bus bundle: pipeline write port, VGA read port and single-port RAM port.
interface fb_arbiter_if #(
  parameter int unsigned ADDR_W = 16,
  parameter int unsigned DATA_W = 8
);
  logic              wr_valid;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic              wr_ready;
  logic              rd_valid;
  logic [ADDR_W-1:0] rd_addr;
  logic [DATA_W-1:0] rd_data;
  logic              rd_data_valid;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_we;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  // Arbiter side
  modport slave (
    input  wr_valid, wr_addr, wr_data, rd_valid, rd_addr, mem_rdata,
    output wr_ready, rd_data, rd_data_valid, mem_addr, mem_we, mem_wdata
  );

  // Requester / RAM side
  modport master (
    output wr_valid, wr_addr, wr_data, rd_valid, rd_addr, mem_rdata,
    input  wr_ready, rd_data, rd_data_valid, mem_addr, mem_we, mem_wdata
  );
endinterface

// File: rtl/fb_arbiter.sv
// Frame-buffer RAM arbiter: VGA reads win every cycle, pipeline writes take the leftover cycles.
// Build option FBARB_WBUF_EN: writes are queued in a WBUF_DEPTH-entry FIFO and drained on
// non-read cycles. Without it, writes go straight to RAM whenever no read is requested.
module fb_arbiter #(
  parameter int unsigned ADDR_W     = 16,
  parameter int unsigned DATA_W     = 8,
  parameter int unsigned WBUF_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst,
  fb_arbiter_if.slave       bus,
  output logic              wbuf_empty,
  output logic [15:0]       stall_cnt
);
  localparam int unsigned CNT_W = 16;

  // Reject unusable buffer depths at elaboration
  if ((WBUF_DEPTH < 2) || ((WBUF_DEPTH & (WBUF_DEPTH - 1)) != 0)) begin : g_bad_depth
    $error("WBUF_DEPTH must be a power of two and at least 2");
  end

  logic              wr_ready_c;
  logic              wr_avail;
  logic [ADDR_W-1:0] wr_head_addr;
  logic [DATA_W-1:0] wr_head_data;
  logic              grant_rd;
  logic              grant_wr;
  logic              rd_data_valid_q;
  logic [CNT_W-1:0]  stall_cnt_q;
  logic [CNT_W-1:0]  stall_cnt_d;

  // Reads always win; nothing is granted while reset is held
  assign grant_rd = rst && bus.rd_valid;
  assign grant_wr = rst && !bus.rd_valid && wr_avail;

`ifdef FBARB_WBUF_EN
  localparam int unsigned PTR_W = $clog2(WBUF_DEPTH);
  localparam int unsigned OCC_W = PTR_W + 1;

  logic [ADDR_W-1:0] addr_mem [WBUF_DEPTH];
  logic [DATA_W-1:0] data_mem [WBUF_DEPTH];
  logic [PTR_W-1:0]  wptr_q, wptr_d;
  logic [PTR_W-1:0]  rptr_q, rptr_d;
  logic [OCC_W-1:0]  occ_q, occ_d;
  logic              push;
  logic              pop;

  // Ready from registered occupancy only, so a same-cycle drain never opens a slot
  assign wr_ready_c   = rst && (occ_q < OCC_W'(WBUF_DEPTH));
  assign push         = bus.wr_valid && wr_ready_c;
  assign pop          = grant_wr;
  assign wr_avail     = (occ_q != '0);
  assign wr_head_addr = addr_mem[rptr_q];
  assign wr_head_data = data_mem[rptr_q];
  assign wbuf_empty   = (occ_q == '0);

  // FIFO pointer and occupancy update
  always_comb begin
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    occ_d  = occ_q;
    if (push) wptr_d = wptr_q + PTR_W'(1);
    if (pop)  rptr_d = rptr_q + PTR_W'(1);
    case ({push, pop})
      2'b10:   occ_d = occ_q + OCC_W'(1);
      2'b01:   occ_d = occ_q - OCC_W'(1);
      default: occ_d = occ_q;
    endcase
  end

  // FIFO control state; reset discards every queued write
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wptr_q <= '0;
      rptr_q <= '0;
      occ_q  <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      occ_q  <= occ_d;
    end
  end

  // FIFO storage; contents are meaningless until occupancy covers them
  always_ff @(posedge clk) begin
    if (push) begin
      addr_mem[wptr_q] <= bus.wr_addr;
      data_mem[wptr_q] <= bus.wr_data;
    end
  end
`else
  assign wr_ready_c   = rst && !bus.rd_valid;
  assign wr_avail     = bus.wr_valid;
  assign wr_head_addr = bus.wr_addr;
  assign wr_head_data = bus.wr_data;
  assign wbuf_empty   = 1'b1;
`endif

  // RAM port mux: READ, WRITE or IDLE (all zero)
  always_comb begin
    bus.mem_addr  = '0;
    bus.mem_we    = 1'b0;
    bus.mem_wdata = '0;
    if (grant_rd) begin
      bus.mem_addr = bus.rd_addr;
    end else if (grant_wr) begin
      bus.mem_addr  = wr_head_addr;
      bus.mem_we    = 1'b1;
      bus.mem_wdata = wr_head_data;
    end
  end

  // Saturating count of cycles a write was offered but refused
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (bus.wr_valid && !wr_ready_c && (stall_cnt_q != '1)) begin
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
    end
  end

  // Read-valid pipeline and stall counter registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_data_valid_q <= 1'b0;
      stall_cnt_q     <= '0;
    end else begin
      rd_data_valid_q <= grant_rd;
      stall_cnt_q     <= stall_cnt_d;
    end
  end

  assign bus.wr_ready      = wr_ready_c;
  assign bus.rd_data       = bus.mem_rdata;
  assign bus.rd_data_valid = rd_data_valid_q;
  assign stall_cnt         = stall_cnt_q;
endmodule

// File: tb/tb_fb_arbiter.sv
// Self-checking bench for fb_arbiter: grant vectors, read/write scoreboards, reset and saturation.
module tb_fb_arbiter;
  logic clk;
  logic rst;
  logic        wbuf_empty;
  logic [15:0] stall_cnt;

  fb_arbiter_if #(.ADDR_W(16), .DATA_W(8)) bus ();

  fb_arbiter #(.ADDR_W(16), .DATA_W(8), .WBUF_DEPTH(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .bus        (bus),
    .wbuf_empty (wbuf_empty),
    .stall_cnt  (stall_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  logic [7:0]  ram [0:65535];
  logic [7:0]  rd_exp;
  logic        rd_prev = 1'b0;
  logic [23:0] wq [$];
  logic [7:0]  rq [$];

  function automatic logic [7:0] pat(input logic [15:0] a);
    return a[7:0] ^ a[15:8];
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Synchronous single-port RAM model, one-cycle read latency
  always @(posedge clk) begin
    if (bus.mem_we) ram[bus.mem_addr] <= bus.mem_wdata;
    bus.mem_rdata <= ram[bus.mem_addr];
  end

  // Scoreboard: read data one cycle after each grant, writes in acceptance order
  always @(negedge clk) begin
    if (!rst) begin
      chk("rst_mem_we", 32'(bus.mem_we), 32'd0);
      chk("rst_rd_data_valid", 32'(bus.rd_data_valid), 32'd0);
      wq.delete();
      rq.delete();
      rd_prev = 1'b0;
    end else begin
      chk("rd_data_valid", 32'(bus.rd_data_valid), 32'(rd_prev));
      if (rd_prev && rq.size() != 0) chk("rd_data", 32'(bus.rd_data), 32'(rq.pop_front()));
      rd_prev = bus.rd_valid;
      if (bus.rd_valid) rq.push_back(rd_exp);
      if (bus.wr_valid && bus.wr_ready) wq.push_back({bus.wr_addr, bus.wr_data});
      if (bus.mem_we) begin
        if (wq.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL spurious_write: got addr 0x%0h data 0x%0h, expected no write",
                   bus.mem_addr, bus.mem_wdata);
        end else begin
          chk("write_order", 32'({bus.mem_addr, bus.mem_wdata}), 32'(wq.pop_front()));
        end
      end
    end
  end

  task automatic drive(input logic rv, input logic [15:0] ra, input logic [7:0] re,
                       input logic wv, input logic [15:0] wa, input logic [7:0] wd);
    bus.rd_valid = rv;
    bus.rd_addr  = ra;
    rd_exp       = re;
    bus.wr_valid = wv;
    bus.wr_addr  = wa;
    bus.wr_data  = wd;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

`ifndef FBARB_WBUF_EN
  typedef struct {
    logic        rv;
    logic [15:0] ra;
    logic [7:0]  re;
    logic        wv;
    logic [15:0] wa;
    logic [7:0]  wd;
    logic        e_we;
    logic [15:0] e_addr;
    logic [7:0]  e_wdata;
    logic        e_rdy;
  } vec_t;

  localparam int NVEC = 13;
  vec_t tbl [NVEC];
`else
  // Offer n writes while reads hold the RAM; each one must be accepted
  task automatic fill(input logic [15:0] a0, input logic [7:0] d0, input int n);
    for (int i = 0; i < n; i++) begin
      drive(1'b1, 16'h0010, 8'h10, 1'b1, a0 + 16'(i), d0 + 8'(i));
      @(negedge clk);
      chk("fill_wr_ready", 32'(bus.wr_ready), 32'd1);
      next_cycle();
    end
  endtask
`endif

  initial begin
    for (int i = 0; i < 65536; i++) ram[i] = pat(16'(i));
    bus.mem_rdata = '0;
    rst = 1'b0;
    drive(1'b1, 16'h1234, 8'h00, 1'b1, 16'h4321, 8'h99);

    // Reset state with both requesters active
    repeat (2) @(negedge clk);
    chk("rst_wr_ready", 32'(bus.wr_ready), 32'd0);
    chk("rst_mem_addr", 32'(bus.mem_addr), 32'd0);
    chk("rst_mem_wdata", 32'(bus.mem_wdata), 32'd0);
    chk("rst_wbuf_empty", 32'(wbuf_empty), 32'd1);
    chk("rst_stall_cnt", 32'(stall_cnt), 32'd0);

    next_cycle();
    drive(1'b0, 16'h0, 8'h0, 1'b0, 16'h0, 8'h0);
    rst = 1'b1;

`ifndef FBARB_WBUF_EN
    tbl[0]  = '{1'b1, 16'h0010, 8'h10, 1'b0, 16'h0000, 8'h00, 1'b0, 16'h0010, 8'h00, 1'b0};
    tbl[1]  = '{1'b0, 16'h0000, 8'h00, 1'b0, 16'h0000, 8'h00, 1'b0, 16'h0000, 8'h00, 1'b1};
    tbl[2]  = '{1'b0, 16'h0000, 8'h00, 1'b1, 16'h1234, 8'h5A, 1'b1, 16'h1234, 8'h5A, 1'b1};
    tbl[3]  = '{1'b1, 16'h1234, 8'h5A, 1'b1, 16'h2222, 8'h77, 1'b0, 16'h1234, 8'h00, 1'b0};
    tbl[4]  = '{1'b0, 16'h0000, 8'h00, 1'b1, 16'h2222, 8'h77, 1'b1, 16'h2222, 8'h77, 1'b1};
    tbl[5]  = '{1'b1, 16'h2222, 8'h77, 1'b0, 16'h0000, 8'h00, 1'b0, 16'h2222, 8'h00, 1'b0};
    tbl[6]  = '{1'b1, 16'h0000, 8'h00, 1'b0, 16'h0000, 8'h00, 1'b0, 16'h0000, 8'h00, 1'b0};
    tbl[7]  = '{1'b0, 16'h0000, 8'h00, 1'b1, 16'hFFFF, 8'hFF, 1'b1, 16'hFFFF, 8'hFF, 1'b1};
    tbl[8]  = '{1'b1, 16'hFFFF, 8'hFF, 1'b0, 16'h0000, 8'h00, 1'b0, 16'hFFFF, 8'h00, 1'b0};
    tbl[9]  = '{1'b0, 16'h0000, 8'h00, 1'b0, 16'h0000, 8'h00, 1'b0, 16'h0000, 8'h00, 1'b1};
    tbl[10] = '{1'b0, 16'h0000, 8'h00, 1'b1, 16'h0005, 8'h33, 1'b1, 16'h0005, 8'h33, 1'b1};
    tbl[11] = '{1'b0, 16'h0000, 8'h00, 1'b1, 16'h0006, 8'h44, 1'b1, 16'h0006, 8'h44, 1'b1};
    tbl[12] = '{1'b0, 16'h0000, 8'h00, 1'b0, 16'h0000, 8'h00, 1'b0, 16'h0000, 8'h00, 1'b1};

    // Single-cycle grant vectors
    for (int i = 0; i < NVEC; i++) begin
      next_cycle();
      drive(tbl[i].rv, tbl[i].ra, tbl[i].re, tbl[i].wv, tbl[i].wa, tbl[i].wd);
      @(negedge clk);
      chk($sformatf("vec%0d_mem_we", i), 32'(bus.mem_we), 32'(tbl[i].e_we));
      chk($sformatf("vec%0d_mem_addr", i), 32'(bus.mem_addr), 32'(tbl[i].e_addr));
      chk($sformatf("vec%0d_wr_ready", i), 32'(bus.wr_ready), 32'(tbl[i].e_rdy));
      if (!tbl[i].rv) chk($sformatf("vec%0d_mem_wdata", i), 32'(bus.mem_wdata), 32'(tbl[i].e_wdata));
    end
    chk("table_stall_cnt", 32'(stall_cnt), 32'd1);

    // Ten cycles of read pressure starve a pending write; it lands as soon as reads stop
    next_cycle();
    drive(1'b1, 16'h0010, 8'h10, 1'b1, 16'h0300, 8'hC3);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("starve_mem_we", 32'(bus.mem_we), 32'd0);
      chk("starve_wr_ready", 32'(bus.wr_ready), 32'd0);
    end
    next_cycle();
    bus.rd_valid = 1'b0;
    @(negedge clk);
    chk("starve_stall_cnt", 32'(stall_cnt), 32'd11);
    chk("release_mem_we", 32'(bus.mem_we), 32'd1);
    chk("release_mem_addr", 32'(bus.mem_addr), 32'h0300);
    chk("release_mem_wdata", 32'(bus.mem_wdata), 32'hC3);

    // Reset mid-write kills the RAM write at once; first edge after release arbitrates normally
    next_cycle();
    drive(1'b0, 16'h0, 8'h0, 1'b1, 16'h0400, 8'h44);
    #1 rst = 1'b0;
    #1;
    chk("midrst_mem_we", 32'(bus.mem_we), 32'd0);
    chk("midrst_mem_addr", 32'(bus.mem_addr), 32'd0);
    chk("midrst_wr_ready", 32'(bus.wr_ready), 32'd0);
    chk("midrst_stall_cnt", 32'(stall_cnt), 32'd0);
    @(negedge clk);
    next_cycle();
    rst = 1'b1;
    @(negedge clk);
    chk("postrst_wr_ready", 32'(bus.wr_ready), 32'd1);
    chk("postrst_mem_we", 32'(bus.mem_we), 32'd1);
    chk("postrst_mem_addr", 32'(bus.mem_addr), 32'h0400);
    next_cycle();
    bus.wr_valid = 1'b0;
`else
    // Four writes queue up behind continuous reads, then drain in order
    fill(16'h0100, 8'hA0, 4);
    bus.wr_valid = 1'b0;
    @(negedge clk);
    chk("full_wr_ready", 32'(bus.wr_ready), 32'd0);
    chk("full_wbuf_empty", 32'(wbuf_empty), 32'd0);
    chk("full_mem_we", 32'(bus.mem_we), 32'd0);
    next_cycle();
    bus.rd_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("drain_mem_we", 32'(bus.mem_we), 32'd1);
      chk("drain_mem_addr", 32'(bus.mem_addr), 32'h0100 + 32'(i));
      chk("drain_mem_wdata", 32'(bus.mem_wdata), 32'hA0 + 32'(i));
      next_cycle();
    end
    @(negedge clk);
    chk("drained_wbuf_empty", 32'(wbuf_empty), 32'd1);
    chk("drained_mem_we", 32'(bus.mem_we), 32'd0);

    // Full FIFO: a drain in the same cycle does not open a slot for the new write
    fill(16'h0200, 8'hB0, 4);
    drive(1'b0, 16'h0, 8'h0, 1'b1, 16'h0204, 8'hB4);
    @(negedge clk);
    chk("fulldrain_wr_ready", 32'(bus.wr_ready), 32'd0);
    chk("fulldrain_mem_addr", 32'(bus.mem_addr), 32'h0200);
    next_cycle();
    @(negedge clk);
    chk("afterdrain_wr_ready", 32'(bus.wr_ready), 32'd1);
    next_cycle();
    bus.wr_valid = 1'b0;
    for (int i = 0; i < 10 && !wbuf_empty; i++) next_cycle();
    chk("fulldrain_wbuf_empty", 32'(wbuf_empty), 32'd1);

    // Reset with three buffered writes discards them
    fill(16'h0300, 8'hC0, 3);
    drive(1'b0, 16'h0, 8'h0, 1'b0, 16'h0, 8'h0);
    #1 rst = 1'b0;
    #1;
    chk("midrst_mem_we", 32'(bus.mem_we), 32'd0);
    chk("midrst_wbuf_empty", 32'(wbuf_empty), 32'd1);
    chk("midrst_wr_ready", 32'(bus.wr_ready), 32'd0);
    @(negedge clk);
    next_cycle();
    rst = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      chk("postrst_mem_we", 32'(bus.mem_we), 32'd0);
      chk("postrst_wbuf_empty", 32'(wbuf_empty), 32'd1);
    end
`endif

    // Long read pressure saturates the stall counter and it stays there
    next_cycle();
    drive(1'b1, 16'h0010, 8'h10, 1'b1, 16'h0500, 8'h55);
    repeat (70000) @(posedge clk);
    @(negedge clk);
    chk("sat_stall_cnt", 32'(stall_cnt), 32'hFFFF);
    repeat (5) @(posedge clk);
    @(negedge clk);
    chk("sat_hold_stall_cnt", 32'(stall_cnt), 32'hFFFF);
    next_cycle();
    drive(1'b0, 16'h0, 8'h0, 1'b0, 16'h0, 8'h0);
    for (int i = 0; i < 20 && !wbuf_empty; i++) next_cycle();
    repeat (2) next_cycle();
    @(negedge clk);
    chk("end_wbuf_empty", 32'(wbuf_empty), 32'd1);
    chk("end_writes_outstanding", 32'(wq.size()), 32'd0);
    chk("end_reads_outstanding", 32'(rq.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/fb_arbiter.md
FB_ARBITER -- requirements
Module: fb_arbiter

Interface
REQ-001 SHALL have parameters ADDR_W, default 16, frame-buffer address width.
REQ-002 SHALL have parameters DATA_W, default 8, pixel width.
REQ-003 SHALL have parameters WBUF_DEPTH, default 4, write-buffer entries (power of two, at least 2).
REQ-004 clk  input  1  single clock; all state on rising edge.
REQ-005 rst  input  1  reset, asynchronous, active-low.
REQ-006 wr_valid  input  1  pipeline memory-write stage offers a pixel write.
REQ-007 wr_addr  input  ADDR_W  write address.
REQ-008 wr_data  input  DATA_W  write pixel.
REQ-009 wr_ready  output  1  write accepted when wr_valid and wr_ready are both high.
REQ-010 rd_valid  input  1  VGA pixel-read request; never stalled.
REQ-011 rd_addr  input  ADDR_W  read address.
REQ-012 rd_data  output  DATA_W  read pixel, equal to mem_rdata.
REQ-013 rd_data_valid  output  1  rd_data holds the pixel requested in the previous cycle.
REQ-014 mem_addr  output  ADDR_W  single-port RAM address.
REQ-015 mem_we  output  1  RAM write enable.
REQ-016 mem_wdata  output  DATA_W  RAM write data.
REQ-017 mem_rdata  input  DATA_W  RAM synchronous read data, one-cycle latency.
REQ-018 wbuf_empty  output  1  no write pending inside the block.
REQ-019 stall_cnt  output  16  count of cycles with wr_valid high and wr_ready low.

Function
REQ-020 Each cycle SHALL grant the RAM to exactly one of READ, WRITE or IDLE; READ has absolute priority.
REQ-021 READ grant: rd_valid high -> mem_addr=rd_addr, mem_we=0.
REQ-022 rd_data_valid SHALL be high exactly one cycle after each READ grant.
REQ-023 WRITE grant: no rd_valid and a write available -> mem_addr/mem_wdata from that write, mem_we=1.
REQ-024 IDLE: mem_we=0, mem_addr=0, mem_wdata=0.
REQ-025 Writes SHALL reach RAM in acceptance order; none lost or duplicated.
REQ-026 Buffer occupancy SHALL change by +1 on accept-only, -1 on drain-only, 0 on both or neither.
REQ-027 wr_ready SHALL depend only on registered state (occupancy), never combinationally on wr_valid.
REQ-028 stall_cnt SHALL saturate at 0xFFFF, not wrap.
REQ-029 Read-after-write to an address still buffered SHALL return the old RAM contents; consumers SHALL gate on wbuf_empty.
REQ-030 Continuous rd_valid SHALL starve writes indefinitely; wr_valid SHALL remain stable until accepted.

Reset
REQ-031 While rst low: wr_ready=0, mem_we=0, mem_addr=0, mem_wdata=0, rd_data_valid=0, wbuf_empty=1, stall_cnt=0.
REQ-032 Asserting rst mid-operation SHALL discard buffered writes immediately; no RAM write SHALL occur while rst is low.
REQ-033 The first rising edge after rst release SHALL be a normal arbitration cycle.

Configuration
REQ-034 Macro FBARB_WBUF_EN defined: writes pass through a WBUF_DEPTH-entry FIFO; wr_ready = occupancy < WBUF_DEPTH.
REQ-035 With FBARB_WBUF_EN, writes reach RAM one or more cycles after acceptance; the FIFO drains on any non-READ cycle.
REQ-036 With FBARB_WBUF_EN, push into a full FIFO is impossible even when a drain occurs in the same cycle.
REQ-037 Macro FBARB_WBUF_EN undefined: no FIFO; wr_ready = ~rd_valid, out of reset.
REQ-038 Without FBARB_WBUF_EN, an accepted write hits RAM in the same cycle and wbuf_empty is tied to 1.

Verification
REQ-039 Directed: rd_valid=1, rd_addr=0x0010 -> mem_addr=0x0010, mem_we=0; next cycle rd_data_valid=1, rd_data=mem_rdata.
REQ-040 Directed, buffer on: 4 writes (0x0100..0x0103, data 0xA0..0xA3) with rd_valid held 1 -> wr_ready=0 after the 4th; drop rd_valid -> 4 consecutive mem_we cycles in order 0xA0..0xA3, then wbuf_empty=1.
REQ-041 Directed, buffer on, full: drain and new wr_valid in the same cycle -> no accept that cycle; accepted the next cycle.
REQ-042 Directed, buffer off: wr_valid=1 and rd_valid=1 for 10 cycles -> no mem_we, stall_cnt=10; release rd_valid -> mem_we next cycle.
REQ-043 Directed: assert rst with 3 writes buffered -> mem_we=0 immediately, wbuf_empty=1; after release no stale write appears.
REQ-044 Directed: force 70000 stalled cycles -> stall_cnt=0xFFFF and holds.
